// File: rtl/wait_pkg.sv
// wait_pkg: shared types for the wait-register controller.
// One-hot state encoding plus default timeout and counter width.
package wait_pkg;

  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 8;

  localparam int I_IDLE   = 0;
  localparam int I_PAUSE  = 1;
  localparam int I_SAVE   = 2;
  localparam int I_WAIT   = 3;
  localparam int I_RESUME = 4;
  localparam int I_FLUSH  = 5;
  localparam int I_ABORT  = 6;

  typedef enum logic [6:0] {
    S_IDLE   = 7'b0000001,
    S_PAUSE  = 7'b0000010,
    S_SAVE   = 7'b0000100,
    S_WAIT   = 7'b0001000,
    S_RESUME = 7'b0010000,
    S_FLUSH  = 7'b0100000,
    S_ABORT  = 7'b1000000
  } state_e;

endpackage

// File: rtl/wait_regs_ctrl_if.sv
// wait_regs_ctrl_if: stall handshake and wait-bank strobes.
// master = controller side, slave = requester / bank side.
interface wait_regs_ctrl_if #(
  parameter int CNT_W = wait_pkg::CNT_W_DEF
);

  logic             enable;
  logic             stall_req;
  logic             stall_done;
  logic             flush;
  logic             pause;
  logic             save;
  logic             resume;
  logic             delete;
  logic             stall_out;
  logic             replay_valid;
  logic             timeout_err;
  logic [CNT_W-1:0] wait_cnt;

  modport master (
    input  enable, stall_req, stall_done, flush,
    output pause, save, resume, delete,
    output stall_out, replay_valid,
    output timeout_err, wait_cnt
  );

  modport slave (
    output enable, stall_req, stall_done, flush,
    input  pause, save, resume, delete,
    input  stall_out, replay_valid,
    input  timeout_err, wait_cnt
  );

endinterface

// File: rtl/wait_counter.sv
// wait_counter: clearable saturating up-counter.
// Ports: clk, rst_n, clr, inc -> cnt (CNT_W bits).
module wait_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && cnt_q != MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/wait_regs_ctrl.sv
// wait_regs_ctrl: parks a pipeline stage in wait registers.
// Ports: clk, resetn, bus (master: stall handshake in, bank strobes out).
module wait_regs_ctrl
  import wait_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  wait_regs_ctrl_if.master  bus
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             replay_q, replay_d;
  logic             cnt_clr, cnt_inc;
  logic [CNT_W-1:0] cnt;
  logic             en;

  assign en = bus.enable;

  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    replay_d = replay_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    if (en) begin
      replay_d = 1'b0;
      unique case (1'b1)
        state_q[I_IDLE]: begin
          if (bus.flush)          state_d = S_FLUSH;
          else if (bus.stall_req) state_d = S_PAUSE;
        end
        state_q[I_PAUSE]:
          state_d = bus.flush ? S_FLUSH : S_SAVE;
        state_q[I_SAVE]:
          state_d = bus.flush ? S_FLUSH : S_WAIT;
        state_q[I_WAIT]: begin
          if (bus.flush)
            state_d = S_FLUSH;
          else if (bus.stall_done || done_q)
            state_d = S_RESUME;
          else if (cnt == TMO)
            state_d = S_ABORT;
          // An exit on a remembered early done is not a real
          // wait cycle; the count also stops at TIMEOUT.
          cnt_inc = !done_q && (cnt != TMO);
        end
        state_q[I_RESUME]: begin
          state_d  = bus.flush ? S_FLUSH : S_IDLE;
          replay_d = !bus.flush;
        end
        state_q[I_FLUSH]:
          state_d = S_IDLE;
        default:
          state_d = bus.flush ? S_FLUSH : S_IDLE;
      endcase
      cnt_clr = (state_d == S_PAUSE);
      // Remember a done that arrives before WAIT is reached.
      done_d = (state_d == S_SAVE || state_d == S_WAIT) &&
               (done_q || (bus.stall_done &&
                (state_q[I_PAUSE] || state_q[I_SAVE])));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      replay_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      replay_q <= replay_d;
    end
  end

  wait_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (resetn),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  assign bus.pause        = en & state_q[I_PAUSE];
  assign bus.save         = en & state_q[I_SAVE];
  assign bus.resume       = en & state_q[I_RESUME];
  assign bus.delete       = en & (state_q[I_FLUSH] |
                                  state_q[I_ABORT]);
  assign bus.timeout_err  = en & state_q[I_ABORT];
  assign bus.replay_valid = en & replay_q;
  assign bus.stall_out    = state_q[I_PAUSE] | state_q[I_SAVE] |
                            state_q[I_WAIT]  | state_q[I_RESUME];
  assign bus.wait_cnt     = cnt;

endmodule

// File: tb/tb_wait_regs_ctrl.sv
// tb_wait_regs_ctrl: directed vector bench for wait_regs_ctrl.
// DUT built with TIMEOUT=4 so the abort path is short.
module tb_wait_regs_ctrl;

  localparam int P = 7'b1000000;
  localparam int S = 7'b0100000;
  localparam int R = 7'b0010000;
  localparam int D = 7'b0001000;
  localparam int O = 7'b0000100;
  localparam int V = 7'b0000010;
  localparam int T = 7'b0000001;

  typedef struct {
    logic       en;
    logic       req;
    logic       done;
    logic       fl;
    logic [6:0] out;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  wait_regs_ctrl_if #(.CNT_W(8)) bus ();

  wait_regs_ctrl #(
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  function automatic logic [6:0] outs();
    return {bus.pause, bus.save, bus.resume, bus.delete,
            bus.stall_out, bus.replay_valid, bus.timeout_err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input int en, input int req, input int done,
                     input int fl, input int o, input int c);
    vec_t v;
    v.en   = 1'(en);
    v.req  = 1'(req);
    v.done = 1'(done);
    v.fl   = 1'(fl);
    v.out  = 7'(o);
    v.cnt  = 8'(c);
    vecs.push_back(v);
  endtask

  task automatic drive(input logic en, input logic req,
                       input logic done, input logic fl);
    bus.enable     = en;
    bus.stall_req  = req;
    bus.stall_done = done;
    bus.flush      = fl;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #12;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_cnt", 32'(bus.wait_cnt), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // basic stall
    add(1,1,0,0,0,0);   add(1,1,0,0,P|O,0); add(1,1,0,0,S|O,0);
    add(1,1,0,0,O,0);   add(1,1,0,0,O,1);   add(1,1,0,0,O,2);
    add(1,0,1,0,O,3);   add(1,0,0,0,R|O,4); add(1,0,0,0,V,4);
    add(1,0,0,0,0,4);
    // done during SAVE
    add(1,1,0,0,0,4);   add(1,1,0,0,P|O,0); add(1,0,1,0,S|O,0);
    add(1,0,0,0,O,0);   add(1,0,0,0,R|O,0); add(1,0,0,0,V,0);
    add(1,0,0,0,0,0);
    // timeout
    add(1,1,0,0,0,0);   add(1,1,0,0,P|O,0); add(1,0,0,0,S|O,0);
    add(1,0,0,0,O,0);   add(1,0,0,0,O,1);   add(1,0,0,0,O,2);
    add(1,0,0,0,O,3);   add(1,0,0,0,O,4);   add(1,0,0,0,D|T,4);
    add(1,0,0,0,0,4);   add(1,0,0,0,0,4);
    // flush + done in WAIT
    add(1,1,0,0,0,4);   add(1,1,0,0,P|O,0); add(1,1,0,0,S|O,0);
    add(1,1,0,0,O,0);   add(1,0,1,1,O,1);   add(1,0,0,0,D,2);
    add(1,0,0,0,0,2);   add(1,0,0,0,0,2);
    // flush in RESUME
    add(1,1,0,0,0,2);   add(1,1,0,0,P|O,0); add(1,0,1,0,S|O,0);
    add(1,0,0,0,O,0);   add(1,0,0,1,R|O,0); add(1,0,0,0,D,0);
    add(1,0,0,0,0,0);
    // enable freeze
    add(1,1,0,0,0,0);   add(0,1,0,0,O,0);   add(1,1,0,0,P|O,0);
    add(1,1,0,0,S|O,0); add(1,1,0,0,O,0);   add(0,1,0,0,O,1);
    add(0,1,0,0,O,1);   add(0,1,0,0,O,1);   add(1,1,0,0,O,1);
    add(1,0,1,0,O,2);   add(1,0,0,0,R|O,3); add(0,0,0,0,0,3);
    add(1,0,0,0,V,3);   add(1,0,0,0,0,3);
    // flush in PAUSE, restart with req held, flush in IDLE/FLUSH
    add(1,1,0,0,0,3);   add(1,1,0,1,P|O,0); add(1,1,0,0,D,0);
    add(1,1,0,0,0,0);   add(1,0,0,1,P|O,0); add(1,0,0,0,D,0);
    add(1,0,0,1,0,0);   add(1,0,0,1,D,0);   add(1,0,0,0,0,0);
    add(1,0,0,0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].req, vecs[i].done, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), 32'(outs()),
          32'(vecs[i].out));
      chk($sformatf("vec%0d_cnt", i), 32'(bus.wait_cnt),
          32'(vecs[i].cnt));
      @(posedge clk);
      #1;
    end

    // async reset in SAVE
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("ar_pause", 32'(outs()), 32'(P|O));
    @(posedge clk);
    #1;
    chk("ar_save", 32'(outs()), 32'(S|O));
    #2;
    resetn = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ar_outs_low", 32'(outs()), 32'd0);
    chk("ar_cnt_low", 32'(bus.wait_cnt), 32'd0);
    #4;
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ar_after%0d", k), 32'(outs()), 32'd0);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("ar_restart", 32'(outs()), 32'(P|O));
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
